// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receive engine.
// Frame FSM states, parity-mode encoding and data-length clamp.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_e;

    localparam logic [1:0] PAR_NONE  = 2'd0;
    localparam logic [1:0] PAR_EVEN  = 2'd1;
    localparam logic [1:0] PAR_ODD   = 2'd2;
    localparam logic [1:0] PAR_STICK = 2'd3;

    function automatic logic [1:0] par_mode(
        input logic en,
        input logic odd,
        input logic stick
    );
        if (!en)   return PAR_NONE;
        if (stick) return PAR_STICK;
        if (odd)   return PAR_ODD;
        return PAR_EVEN;
    endfunction

    function automatic logic [3:0] clamp_bits(
        input logic [3:0] bits,
        input logic [3:0] max_bits
    );
        if (bits < 4'd5)     return 4'd5;
        if (bits > max_bits) return max_bits;
        return bits;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchroniser, oversample counter and 3-sample majority vote.
// bit_tick marks the third vote sample; bit_val is valid on that cycle.
module uart_rx_sampler #(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic uart_rxd,
    input  logic baud_tick,
    input  logic cnt_clr,
    output logic line_sync,
    output logic bit_tick,
    output logic bit_val
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] CNT_MAX = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] SMP0    = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] SMP1    = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] SMP2    = CW'(OVERSAMPLE / 2 + 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [1:0]             smp_q, smp_d;

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], uart_rxd};
        line_sync = sync_q[SYNC_STAGES-1];

        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (baud_tick) begin
            cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        end

        smp_d = smp_q;
        if (baud_tick && cnt_q == SMP0) smp_d[0] = line_sync;
        if (baud_tick && cnt_q == SMP1) smp_d[1] = line_sync;

        bit_tick = baud_tick && (cnt_q == SMP2);
        bit_val  = (smp_q[0] & smp_q[1]) | (smp_q[0] & line_sync) |
                   (smp_q[1] & line_sync);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
            cnt_q  <= '0;
            smp_q  <= '0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            smp_q  <= smp_d;
        end
    end

endmodule

// File: rtl/uart_rx_engine.sv
// UART receive engine: frame FSM, shift register, parity/framing/break
// checks and a valid/ready output register with overrun reporting.
module uart_rx_engine
    import uart_rx_pkg::*;
#(
    parameter int MAX_DATA_BITS = 9,
    parameter int OVERSAMPLE    = 16,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                     pclk,
    input  logic                     preset,
    input  logic                     rx_en,
    input  logic                     uart_rxd,
    input  logic                     baud_tick,
    input  logic [3:0]               cfg_data_bits,
    input  logic                     cfg_parity_en,
    input  logic                     cfg_parity_odd,
    input  logic                     cfg_parity_stick,
    input  logic                     cfg_stop2,
    output logic [MAX_DATA_BITS-1:0] rx_data,
    output logic                     rx_parity_err,
    output logic                     rx_frame_err,
    output logic                     rx_break,
    output logic                     rx_valid,
    input  logic                     rx_ready,
    output logic                     overrun_pulse,
    output logic                     rx_busy
);

    localparam int IW = $clog2(MAX_DATA_BITS);

    rx_state_e               state_q, state_d;
    logic [3:0]              len_q, len_d;
    logic [1:0]              mode_q, mode_d;
    logic                    odd_q, odd_d;
    logic                    stop2_q, stop2_d;
    logic [3:0]              bit_cnt_q, bit_cnt_d;
    logic [MAX_DATA_BITS-1:0] shift_q, shift_d;
    logic                    perr_q, perr_d;
    logic                    ferr_q, ferr_d;
    logic                    par_bit_q, par_bit_d;
    logic                    stop_cnt_q, stop_cnt_d;
    logic                    stop0_low_q, stop0_low_d;
    logic [MAX_DATA_BITS-1:0] data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    o_perr_q, o_perr_d;
    logic                    o_ferr_q, o_ferr_d;
    logic                    o_brk_q, o_brk_d;
    logic                    ovr_q, ovr_d;

    logic line_sync, bit_tick, bit_val, cnt_clr;
    logic complete, brk, exp_par;

    assign cnt_clr = (state_q == IDLE) && rx_en && !line_sync;

    uart_rx_sampler #(
        .OVERSAMPLE (OVERSAMPLE),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sampler (
        .clk      (pclk),
        .rst      (preset),
        .uart_rxd (uart_rxd),
        .baud_tick(baud_tick),
        .cnt_clr  (cnt_clr),
        .line_sync(line_sync),
        .bit_tick (bit_tick),
        .bit_val  (bit_val)
    );

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        mode_d      = mode_q;
        odd_d       = odd_q;
        stop2_d     = stop2_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        perr_d      = perr_q;
        ferr_d      = ferr_q;
        par_bit_d   = par_bit_q;
        stop_cnt_d  = stop_cnt_q;
        stop0_low_d = stop0_low_q;
        complete    = 1'b0;
        brk         = 1'b0;
        exp_par     = (mode_q == PAR_STICK) ? !odd_q
                    : ((^shift_q) ^ (mode_q == PAR_ODD));

        unique case (state_q)
            IDLE: begin
                if (cnt_clr) begin
                    state_d     = START;
                    len_d       = clamp_bits(cfg_data_bits, 4'(MAX_DATA_BITS));
                    mode_d      = par_mode(cfg_parity_en, cfg_parity_odd,
                                           cfg_parity_stick);
                    odd_d       = cfg_parity_odd;
                    stop2_d     = cfg_stop2;
                    bit_cnt_d   = '0;
                    shift_d     = '0;
                    perr_d      = 1'b0;
                    ferr_d      = 1'b0;
                    par_bit_d   = 1'b0;
                    stop_cnt_d  = 1'b0;
                    stop0_low_d = 1'b0;
                end
            end
            START: begin
                if (bit_tick) state_d = bit_val ? IDLE : DATA;
            end
            DATA: begin
                if (bit_tick) begin
                    shift_d[bit_cnt_q[IW-1:0]] = bit_val;
                    if (bit_cnt_q == len_q - 4'd1) begin
                        state_d = (mode_q == PAR_NONE) ? STOP : PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_tick) begin
                    par_bit_d = bit_val;
                    perr_d    = bit_val ^ exp_par;
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (bit_tick) begin
                    if (!bit_val) ferr_d = 1'b1;
                    if (stop2_q && !stop_cnt_q) begin
                        stop_cnt_d  = 1'b1;
                        stop0_low_d = !bit_val;
                    end else begin
                        complete = 1'b1;
                        brk      = (shift_q == '0) && !par_bit_q &&
                                   (stop_cnt_q ? stop0_low_q : !bit_val);
                        state_d  = brk ? BREAK : IDLE;
                    end
                end
            end
            BREAK: begin
                if (bit_tick && bit_val) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Disabling the receiver abandons any frame in flight.
        if (!rx_en) begin
            state_d  = IDLE;
            complete = 1'b0;
        end
    end

    always_comb begin
        data_d   = data_q;
        valid_d  = valid_q;
        o_perr_d = o_perr_q;
        o_ferr_d = o_ferr_q;
        o_brk_d  = o_brk_q;
        ovr_d    = 1'b0;

        if (valid_q && rx_ready) valid_d = 1'b0;

        if (complete) begin
            if (!valid_q || rx_ready) begin
                data_d   = shift_q;
                valid_d  = 1'b1;
                o_perr_d = perr_q;
                o_ferr_d = ferr_q | !bit_val;
                o_brk_d  = brk;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q     <= IDLE;
            len_q       <= 4'd5;
            mode_q      <= PAR_NONE;
            odd_q       <= 1'b0;
            stop2_q     <= 1'b0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            par_bit_q   <= 1'b0;
            stop_cnt_q  <= 1'b0;
            stop0_low_q <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            o_perr_q    <= 1'b0;
            o_ferr_q    <= 1'b0;
            o_brk_q     <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            mode_q      <= mode_d;
            odd_q       <= odd_d;
            stop2_q     <= stop2_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            par_bit_q   <= par_bit_d;
            stop_cnt_q  <= stop_cnt_d;
            stop0_low_q <= stop0_low_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            o_perr_q    <= o_perr_d;
            o_ferr_q    <= o_ferr_d;
            o_brk_q     <= o_brk_d;
            ovr_q       <= ovr_d;
        end
    end

    assign rx_data       = data_q;
    assign rx_valid      = valid_q;
    assign rx_parity_err = o_perr_q;
    assign rx_frame_err  = o_ferr_q;
    assign rx_break      = o_brk_q;
    assign overrun_pulse = ovr_q;
    assign rx_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed bench for uart_rx_engine: framing formats, errors, break,
// overrun, enable and reset behaviour with hand-computed expectations.
module tb_uart_rx_engine;

    localparam int BIT_CYC = 64;

    logic       pclk = 1'b0;
    logic       preset = 1'b1;
    logic       rx_en = 1'b0;
    logic       uart_rxd = 1'b1;
    logic       baud_tick = 1'b0;
    logic [3:0] cfg_data_bits = 4'd8;
    logic       cfg_parity_en = 1'b0;
    logic       cfg_parity_odd = 1'b0;
    logic       cfg_parity_stick = 1'b0;
    logic       cfg_stop2 = 1'b0;
    logic [8:0] rx_data;
    logic       rx_parity_err, rx_frame_err, rx_break, rx_valid;
    logic       rx_ready = 1'b0;
    logic       overrun_pulse, rx_busy;

    int  tests = 0;
    int  fails = 0;
    int  bdiv = 0;
    int  rises = 0;
    int  falls = 0;
    int  ovr_cnt = 0;
    logic prev_v = 1'b0;
    time rise_t = 0;
    time t_start = 0;
    int  lat = 0;
    int  d_use = 0;
    int  r0 = 0;
    int  f0 = 0;
    int  o0 = 0;

    uart_rx_engine dut (
        .pclk            (pclk),
        .preset          (preset),
        .rx_en           (rx_en),
        .uart_rxd        (uart_rxd),
        .baud_tick       (baud_tick),
        .cfg_data_bits   (cfg_data_bits),
        .cfg_parity_en   (cfg_parity_en),
        .cfg_parity_odd  (cfg_parity_odd),
        .cfg_parity_stick(cfg_parity_stick),
        .cfg_stop2       (cfg_stop2),
        .rx_data         (rx_data),
        .rx_parity_err   (rx_parity_err),
        .rx_frame_err    (rx_frame_err),
        .rx_break        (rx_break),
        .rx_valid        (rx_valid),
        .rx_ready        (rx_ready),
        .overrun_pulse   (overrun_pulse),
        .rx_busy         (rx_busy)
    );

    always #5 pclk = ~pclk;

    initial begin
        forever begin
            @(negedge pclk);
            #1;
            baud_tick = (bdiv == 0);
            bdiv = (bdiv + 1) % 4;
        end
    end

    initial begin
        forever begin
            @(negedge pclk);
            if (rx_valid && !prev_v) begin
                rises = rises + 1;
                rise_t = $time;
            end
            if (!rx_valid && prev_v) falls = falls + 1;
            if (overrun_pulse) ovr_cnt = ovr_cnt + 1;
            prev_v = rx_valid;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests = tests + 1;
        if (got !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic send_bit(input logic b);
        uart_rxd = b;
        wait_cyc(BIT_CYC);
    endtask

    task automatic align();
        @(negedge pclk);
        while (bdiv != 0) @(negedge pclk);
    endtask

    task automatic cfg(input logic [3:0] nb, input logic pen,
                       input logic podd, input logic pstk, input logic s2);
        cfg_data_bits    = nb;
        cfg_parity_en    = pen;
        cfg_parity_odd   = podd;
        cfg_parity_stick = pstk;
        cfg_stop2        = s2;
    endtask

    task automatic send_frame(input logic [8:0] d, input int nb,
                              input bit par_on, input logic par,
                              input logic s1, input bit two,
                              input logic s2);
        align();
        t_start = $time;
        send_bit(1'b0);
        for (int i = 0; i < nb; i++) send_bit(d[i]);
        if (par_on) send_bit(par);
        send_bit(s1);
        if (two) send_bit(s2);
        uart_rxd = 1'b1;
        wait_cyc(2 * BIT_CYC);
    endtask

    task automatic pop();
        @(negedge pclk);
        rx_ready = 1'b1;
        @(negedge pclk);
        rx_ready = 1'b0;
    endtask

    function automatic logic [31:0] flags();
        return 32'({rx_parity_err, rx_frame_err, rx_break});
    endfunction

    initial begin
        wait_cyc(3);
        check("rst_data", 32'(rx_data), 32'h0);
        check("rst_ctrl", 32'({rx_valid, rx_parity_err, rx_frame_err,
                               rx_break, overrun_pulse, rx_busy}), 32'h0);
        preset = 1'b0;
        rx_en = 1'b1;
        wait_cyc(8);

        cfg(4'd8, 1'b0, 1'b0, 1'b0, 1'b0);
        r0 = rises;
        send_frame(9'h0A5, 8, 0, 1'b0, 1'b1, 0, 1'b1);
        check("a5_rise", 32'(rises - r0), 32'd1);
        check("a5_data", 32'(rx_data), 32'h0A5);
        check("a5_flags", flags(), 32'h0);
        check("a5_busy", 32'(rx_busy), 32'h0);
        lat = int'((rise_t - t_start) / 10);
        check("a5_latency_window", 32'(lat >= 612 && lat <= 624), 32'd1);
        d_use = (lat >= 612 && lat <= 624) ? lat : 616;
        pop();

        cfg(4'd7, 1'b1, 1'b0, 1'b0, 1'b1);
        send_frame(9'h03C, 7, 1, 1'b1, 1'b1, 1, 1'b1);
        check("7e2_perr_data", 32'(rx_data), 32'h03C);
        check("7e2_perr_flags", flags(), 32'h4);
        pop();
        send_frame(9'h03C, 7, 1, 1'b0, 1'b1, 1, 1'b0);
        check("7e2_ferr_data", 32'(rx_data), 32'h03C);
        check("7e2_ferr_flags", flags(), 32'h2);
        pop();

        cfg(4'd9, 1'b1, 1'b1, 1'b0, 1'b0);
        send_frame(9'h1FF, 9, 1, 1'b0, 1'b1, 0, 1'b1);
        check("9o1_data", 32'(rx_data), 32'h1FF);
        check("9o1_flags", flags(), 32'h0);
        pop();
        r0 = rises;
        align();
        uart_rxd = 1'b0;
        wait_cyc(16);
        uart_rxd = 1'b1;
        wait_cyc(8);
        check("glitch_busy", 32'(rx_busy), 32'h1);
        wait_cyc(2 * BIT_CYC);
        check("glitch_idle", 32'(rx_busy), 32'h0);
        check("glitch_novalid", 32'(rises - r0), 32'd0);

        cfg(4'd8, 1'b0, 1'b0, 1'b0, 1'b0);
        r0 = rises;
        align();
        uart_rxd = 1'b0;
        wait_cyc(30 * BIT_CYC);
        check("brk_hold_busy", 32'(rx_busy), 32'h1);
        uart_rxd = 1'b1;
        wait_cyc(2 * BIT_CYC);
        check("brk_exit_idle", 32'(rx_busy), 32'h0);
        check("brk_one_frame", 32'(rises - r0), 32'd1);
        check("brk_data", 32'(rx_data), 32'h0);
        check("brk_flags", flags(), 32'h3);
        pop();
        send_frame(9'h055, 8, 0, 1'b0, 1'b1, 0, 1'b1);
        check("post_brk_data", 32'(rx_data), 32'h055);
        check("post_brk_flags", flags(), 32'h0);
        pop();

        o0 = ovr_cnt;
        send_frame(9'h011, 8, 0, 1'b0, 1'b1, 0, 1'b1);
        send_frame(9'h022, 8, 0, 1'b0, 1'b1, 0, 1'b1);
        check("ovr_keep_old", 32'(rx_data), 32'h011);
        check("ovr_pulse_once", 32'(ovr_cnt - o0), 32'd1);
        check("ovr_valid", 32'(rx_valid), 32'h1);
        f0 = falls;
        fork
            send_frame(9'h033, 8, 0, 1'b0, 1'b1, 0, 1'b1);
            begin
                @(negedge uart_rxd);
                repeat (d_use - 1) @(negedge pclk);
                rx_ready = 1'b1;
                @(negedge pclk);
                rx_ready = 1'b0;
            end
        join
        check("swap_data", 32'(rx_data), 32'h033);
        check("swap_valid_cont", 32'(falls - f0), 32'd0);
        check("swap_valid", 32'(rx_valid), 32'h1);
        check("swap_no_ovr", 32'(ovr_cnt - o0), 32'd1);
        pop();

        r0 = rises;
        align();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        uart_rxd = 1'b0;
        wait_cyc(32);
        check("en_busy_before", 32'(rx_busy), 32'h1);
        rx_en = 1'b0;
        @(negedge pclk);
        check("en_off_idle", 32'(rx_busy), 32'h0);
        wait_cyc(32);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        wait_cyc(2 * BIT_CYC);
        check("en_off_novalid", 32'(rises - r0), 32'd0);
        rx_en = 1'b1;
        wait_cyc(4);
        send_frame(9'h081, 8, 0, 1'b0, 1'b1, 0, 1'b1);
        check("en_on_data", 32'(rx_data), 32'h081);
        check("en_on_flags", flags(), 32'h0);

        align();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        check("rst_mid_busy", 32'(rx_busy), 32'h1);
        check("rst_mid_valid", 32'(rx_valid), 32'h1);
        #2;
        preset = 1'b1;
        #1;
        check("rst_mid_data", 32'(rx_data), 32'h0);
        check("rst_mid_ctrl", 32'({rx_valid, rx_parity_err, rx_frame_err,
                                   rx_break, overrun_pulse, rx_busy}),
              32'h0);
        @(negedge pclk);
        uart_rxd = 1'b1;
        wait_cyc(4);
        preset = 1'b0;
        wait_cyc(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_engine.md
Name: uart_rx_engine

Overview:
Parametrised UART receive engine: line synchroniser, oversampled majority-vote bit recovery and frame FSM, with a valid/ready output register. Generalises the fixed 8-bit receive FSM with runtime-configurable data length (5..MAX_DATA_BITS), parity mode, stop-bit count and parametrised oversampling. It adds explicit parity, framing, break and overrun reporting. It sits between the baud-tick generator and the RX FIFO / APB register block.

Parameters:
MAX_DATA_BITS, 9, widest supported data field; rx_data width; legal range 5..9
OVERSAMPLE, 16, baud_tick pulses per bit period; even, >= 8
SYNC_STAGES, 2, flops in the uart_rxd synchroniser; >= 2

Ports:
pclk  in  1  clock
preset  in  1  asynchronous active-high reset
rx_en  in  1  receiver enable
uart_rxd  in  1  asynchronous serial input, idle high
baud_tick  in  1  one-pclk pulse, OVERSAMPLE per bit period
cfg_data_bits  in  4  data bits per frame; clamped to 5..MAX_DATA_BITS
cfg_parity_en  in  1  parity bit present
cfg_parity_odd  in  1  1 = odd, 0 = even
cfg_parity_stick  in  1  parity bit fixed to ~cfg_parity_odd (stick mode)
cfg_stop2  in  1  two stop bits
rx_data  out  MAX_DATA_BITS  received data, LSB = first bit, zero-extended
rx_parity_err  out  1  qualified by rx_valid
rx_frame_err  out  1  qualified by rx_valid
rx_break  out  1  qualified by rx_valid
rx_valid  out  1  output register holds a frame
rx_ready  in  1  consumer accepts the frame
overrun_pulse  out  1  one-cycle pulse: completed frame dropped
rx_busy  out  1  FSM not in IDLE

Behaviour:
- Reset: FSM IDLE, synchroniser flops 1, counters 0. rx_data 0; rx_valid, all error flags, overrun_pulse and rx_busy 0.
- Synchroniser: SYNC_STAGES flops, reset to 1. All decisions use the synchronised line.
- Oversample counter: 0..OVERSAMPLE-1, advances on baud_tick only, wraps to 0. Cleared on entry to START.
- Vote: samples at counts OVERSAMPLE/2-1, OVERSAMPLE/2, OVERSAMPLE/2+1. Bit value = majority (2 of 3), decided on the tick with count OVERSAMPLE/2+1 ("bit tick").
- Config (data bits, parity, stop) is latched on IDLE->START. Changes mid-frame have no effect.
- States and transitions:
  IDLE: rx_en & line==0 -> START.
  START: on bit tick, vote 1 -> IDLE (false start, nothing reported); vote 0 -> DATA.
  DATA: one bit per bit tick, shifted in LSB first. Bit counter runs to latched length. Last bit -> PARITY if enabled, else STOP.
  PARITY: on bit tick, compare against the expected value. Even/odd: XOR of data bits, inverted for odd. Stick: ~cfg_parity_odd. -> STOP.
  STOP: on each stop bit tick (1 or 2 ticks per cfg_stop2), vote 0 sets the frame error. Frame completes on the final stop bit tick. Break condition: all data bits 0, parity bit 0 (if present) and first stop vote 0. On break -> BREAK, otherwise -> IDLE.
  BREAK: stays until the synchronised line is 1 for one full bit tick -> IDLE. No new start detection in this state.
- rx_en=0 in any state: -> IDLE next cycle, partial frame discarded. Output register and rx_valid are untouched.
- Frame completion timing: output register loads on the cycle after the completing bit tick (latency 1 pclk). rx_break=1 implies rx_frame_err=1 and rx_data=0.
- Output handshake:
  - rx_valid holds until rx_valid & rx_ready.
  - Completion with rx_valid=0 -> load.
  - Completion with rx_valid=1 & rx_ready=1 in the same cycle -> load new frame, rx_valid stays 1.
  - Completion with rx_valid=1 & rx_ready=0 -> new frame dropped, old frame kept, overrun_pulse=1 for one cycle.
- A new start bit may be detected on the cycle the FSM returns to IDLE (mid-stop-bit resync).

Decomposition:
- Package uart_rx_pkg: state enum (IDLE, START, DATA, PARITY, STOP, BREAK); parity-mode encoding constants; clamp helper function for cfg_data_bits.
- Sub-module uart_rx_sampler: synchroniser, oversample counter, 3-sample majority vote. Outputs: bit_tick, bit_val, line_sync. The top holds the FSM, shift register, parity/error logic and output register.

Test Plan:
- 8N1, OVERSAMPLE=16, send 0xA5 -> rx_data=0x0A5, rx_valid 1 pclk after stop bit tick, all errors 0, rx_busy 0 afterwards.
- 7 data bits, even parity, 2 stop; send 0x3C with the parity bit flipped -> rx_data=0x3C, rx_parity_err=1. Second stop driven 0 -> rx_frame_err=1.
- 9 data bits, odd parity, 0x1FF; then a 4-tick low glitch on an idle line -> first frame correct; glitch gives START->IDLE with no rx_valid.
- Line held low 3 frame times, 8N1 -> one rx_valid with rx_break=1, rx_frame_err=1, rx_data=0. FSM in BREAK until line high; next frame 0x55 received correctly.
- rx_ready=0 while two frames 0x11, 0x22 arrive -> rx_data stays 0x11, overrun_pulse exactly one cycle. Raising rx_ready on the completion cycle of 0x33 -> 0x33 loaded, rx_valid continuous.
- Deassert rx_en at data bit 4 -> IDLE next cycle, no rx_valid. Reassert rx_en and send 0x81 -> received intact. Assert preset mid-frame -> all outputs 0 immediately.
